core_pipe_exec_mdu: RTL and testbench

Iterative multiply/divide functional unit for the execute stage. It implements the RV64M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, plus the word forms MULW, DIVW, DIVUW, REMW and REMUW. It is generalised over XLEN and over the number of multiplier bits retired per cycle. The execute stage holds the instruction in place until `ready`, then retires it with `ack`; a pipeline flush aborts the operation.

---
 rtl/core_pipe_exec_mdu.sv | 195 +++++++++++++++++++
 tb/tb_core_pipe_exec_mdu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_exec_mdu.sv
// core_pipe_exec_mdu: iterative RV64M multiply/divide unit for the execute stage.
// Multiply is an unsigned shift-add on operand magnitudes (MUL_UNROLL bits per
// cycle). Divide is restoring, one bit per cycle. Sign fix-up and result
// selection are registered on the last BUSY cycle.
// Ports:
//   g_clk, g_reset   clock, asynchronous active-high reset
//   valid            request; op/op_w/rs1/rs2 stable while high
//   ack              execute stage consumed the result
//   flush            abort; highest priority in every state
//   op, op_w         operation select and word (*W) form
//   rs1, rs2         operands
//   busy, ready      state==BUSY, state==DONE
//   result           held while ready
module core_pipe_exec_mdu #(
  parameter int XLEN       = 64,
  parameter int MUL_UNROLL = 1
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            valid,
  input  logic            ack,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic            op_w,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = {XLEN{x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = x;
    return r;
  endfunction

  // ---------------- request decode (used only in IDLE) ----------------
  logic            is_div, is_mulh, word, sgn_a, sgn_b, neg_a, neg_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_w, b_w, a_mag, b_mag, most_neg, fast_res;
  logic [CW-1:0]   n_cyc;

  always_comb begin
    is_div  = op[2];
    // MULH/MULHSU/MULHU ignore op_w and run at full width
    is_mulh = !op[2] && (op[1:0] != 2'd0);
    word    = op_w && !is_mulh;
    sgn_a   = is_div ? !op[0] : (op[1:0] == 2'd1 || op[1:0] == 2'd2);
    sgn_b   = is_div ? !op[0] : (op[1:0] == 2'd1);
    a_w     = rs1;
    b_w     = rs2;
    if (word) begin
      a_w = sgn_a ? sext32(rs1[31:0]) : zext32(rs1[31:0]);
      b_w = sgn_b ? sext32(rs2[31:0]) : zext32(rs2[31:0]);
    end
    neg_a = sgn_a && a_w[XLEN-1];
    neg_b = sgn_b && b_w[XLEN-1];
    a_mag = neg_a ? -a_w : a_w;
    b_mag = neg_b ? -b_w : b_w;

    most_neg           = '0;
    most_neg[XLEN-1]   = 1'b1;
    if (word) most_neg = sext32(32'h8000_0000);
    div_zero = is_div && (b_w == '0);
    div_ovf  = is_div && !op[0] && (a_w == most_neg) && (b_w == '1);

    // Divide-by-zero: quotient all ones, remainder = dividend (sign-extended
    // in word mode even for REMUW). Overflow: quotient = dividend, rem = 0.
    if (div_zero)
      fast_res = op[1] ? (word ? sext32(rs1[31:0]) : rs1) : '1;
    else
      fast_res = op[1] ? '0 : a_w;

    if (is_div) n_cyc = CW'((word ? 32 : XLEN) - 1);
    else        n_cyc = CW'((word ? 32 : XLEN) / MUL_UNROLL - 1);
  end

  // ---------------- latched operation state ----------------
  state_t            st;
  logic [CW-1:0]     cnt;
  logic              div_q, word_q, neg_p, neg_r;
  logic [1:0]        op_q;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier, quot, rem, dvs;

  // ---------------- iteration step ----------------
  logic [2*XLEN-1:0] acc_n, mc_n, prod;
  logic [XLEN-1:0]   mp_n, quot_n, rem_n, q_fix, r_fix, mul_res, div_res;
  logic [XLEN:0]     trial;
  logic              ge;

  always_comb begin
    acc_n = acc;
    mc_n  = mcand;
    mp_n  = mplier;
    for (int u = 0; u < MUL_UNROLL; u++) begin
      if (mp_n[0]) acc_n = acc_n + mc_n;
      mc_n = mc_n << 1;
      mp_n = mp_n >> 1;
    end

    // quot holds the not-yet-consumed dividend bits at the top and the
    // quotient bits shifting in at the bottom
    trial  = {rem, quot[XLEN-1]};
    ge     = trial >= {1'b0, dvs};
    rem_n  = ge ? (trial[XLEN-1:0] - dvs) : trial[XLEN-1:0];
    quot_n = {quot[XLEN-2:0], ge};

    prod    = neg_p ? -acc_n : acc_n;
    mul_res = prod[2*XLEN-1:XLEN];
    if (op_q == 2'd0) mul_res = word_q ? sext32(prod[31:0]) : prod[XLEN-1:0];

    q_fix   = neg_p ? -quot_n : quot_n;
    r_fix   = neg_r ? -rem_n : rem_n;
    div_res = op_q[1] ? r_fix : q_fix;
    if (word_q) div_res = sext32(div_res[31:0]);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      st     <= IDLE;
      cnt    <= '0;
      result <= '0;
      div_q  <= 1'b0;
      word_q <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      op_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      quot   <= '0;
      rem    <= '0;
      dvs    <= '0;
    end else if (flush) begin
      st <= IDLE;
    end else begin
      case (st)
        IDLE: if (valid) begin
          div_q  <= is_div;
          op_q   <= op[1:0];
          word_q <= word;
          neg_p  <= neg_a ^ neg_b;
          neg_r  <= neg_a;
          cnt    <= n_cyc;
          acc    <= '0;
          mcand  <= {{XLEN{1'b0}}, a_mag};
          mplier <= b_mag;
          // left-align a word dividend so quotient bits land in [31:0]
          quot   <= word ? (a_mag << (XLEN - 32)) : a_mag;
          rem    <= '0;
          dvs    <= b_mag;
          if (div_zero || div_ovf) begin
            result <= fast_res;
            st     <= DONE;
          end else begin
            st <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_n;
          mcand  <= mc_n;
          mplier <= mp_n;
          quot   <= quot_n;
          rem    <= rem_n;
          if (cnt == '0) begin
            result <= div_q ? div_res : mul_res;
            st     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: if (ack) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign busy  = (st == BUSY);
  assign ready = (st == DONE);

endmodule

// File: tb/tb_core_pipe_exec_mdu.sv
module tb_core_pipe_exec_mdu;
  logic        g_clk = 1'b0;
  logic        g_reset, valid, ack, flush, op_w;
  logic [2:0]  op;
  logic [63:0] rs1, rs2;
  logic        busy, ready, busy4, ready4;
  logic [63:0] result, result4;
  int          total = 0;
  int          bad   = 0;

  always #5 g_clk = ~g_clk;

  core_pipe_exec_mdu #(.XLEN(64), .MUL_UNROLL(1)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .valid(valid), .ack(ack), .flush(flush),
    .op(op), .op_w(op_w), .rs1(rs1), .rs2(rs2),
    .busy(busy), .ready(ready), .result(result));

  core_pipe_exec_mdu #(.XLEN(64), .MUL_UNROLL(4)) dut4 (
    .g_clk(g_clk), .g_reset(g_reset), .valid(valid), .ack(ack), .flush(flush),
    .op(op), .op_w(op_w), .rs1(rs1), .rs2(rs2),
    .busy(busy4), .ready(ready4), .result(result4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic bit word_mode(input logic [2:0] o, input logic w);
    return w && !(o inside {3'd1, 3'd2, 3'd3});
  endfunction

  // Architectural reference: wide signed/unsigned arithmetic on the operands.
  function automatic logic [63:0] mdl(input logic [2:0] o, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    longint              sa, sb;
    logic [63:0]         ua, ub, mn, r;
    bit                  wd;
    wd = word_mode(o, w);
    sa = wd ? sx32(a[31:0]) : a;
    sb = wd ? sx32(b[31:0]) : b;
    ua = wd ? {32'd0, a[31:0]} : a;
    ub = wd ? {32'd0, b[31:0]} : b;
    mn = wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    r  = '0;
    case (o)
      3'd0: r = a * b;
      3'd1: begin pa = $signed(a); pb = $signed(b); p = pa * pb; r = p[127:64]; end
      3'd2: begin pa = $signed(a); pb = {64'd0, b}; p = pa * pb; r = p[127:64]; end
      3'd3: begin pa = {64'd0, a}; pb = {64'd0, b}; p = pa * pb; r = p[127:64]; end
      3'd4: if (sb == 0) r = '1;
            else if (sa == longint'(mn) && sb == -1) r = sa;
            else r = sa / sb;
      3'd5: r = (ub == 0) ? '1 : ua / ub;
      3'd6: if (sb == 0) r = sa;
            else if (sa == longint'(mn) && sb == -1) r = 0;
            else r = sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    if (wd) r = sx32(r[31:0]);
    return r;
  endfunction

  // Cycle in which ready is first seen (request edge = cycle 0).
  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b, input int u);
    bit          wd;
    int          wbits;
    logic [63:0] aw, bw;
    wd    = word_mode(o, w);
    wbits = wd ? 32 : 64;
    if (!o[2]) return wbits / u + 1;
    bw = wd ? {32'd0, b[31:0]} : b;
    if (bw == 0) return 1;
    if (!o[0]) begin
      aw = wd ? sx32(a[31:0]) : a;
      bw = wd ? sx32(b[31:0]) : b;
      if (aw == (wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000) && bw == '1)
        return 1;
    end
    return wbits + 1;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return sx32($urandom);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one op (called just after a clock edge), time it, check result,
  // check it holds in DONE with valid still high, then ack it.
  task automatic do_op(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int elat, input int elat4);
    int lat, lat4, bc, cyc;
    op = o; op_w = w; rs1 = a; rs2 = b; valid = 1'b1;
    lat = 0; lat4 = 0; bc = 0; cyc = 0;
    while ((lat == 0 || lat4 == 0) && cyc < 200) begin
      @(posedge g_clk); #1;
      cyc++;
      if (busy) bc++;
      if (ready && lat == 0) lat = cyc;
      if (ready4 && lat4 == 0) lat4 = cyc;
    end
    check({tag, ".lat"},   64'(lat),  64'(elat));
    check({tag, ".lat4"},  64'(lat4), 64'(elat4));
    check({tag, ".busy"},  64'(bc),   64'(elat - 1));
    check({tag, ".res"},   result,    exp);
    check({tag, ".res4"},  result4,   exp);
    repeat (2) begin @(posedge g_clk); #1; end
    check({tag, ".hold"},  {63'd0, ready}, 64'd1);
    check({tag, ".holdv"}, result, exp);
    ack = 1'b1; valid = 1'b0;
    @(posedge g_clk); #1;
    ack = 1'b0;
    check({tag, ".ackd"},  {62'd0, ready, ready4}, 64'd0);
  endtask

  initial begin
    int          rc;
    logic [2:0]  o;
    logic        w;
    logic [63:0] a, b;

    g_reset = 1'b1; valid = 1'b0; ack = 1'b0; flush = 1'b0;
    op = 3'd0; op_w = 1'b0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge g_clk);
    #1;
    check("reset.flags", {60'd0, busy, ready, busy4, ready4}, 64'd0);
    check("reset.res", result, 64'd0);
    g_reset = 1'b0;

    do_op("mul",     3'd0, 1'b0, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 65, 17);
    do_op("mulhu",   3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 17);
    do_op("mulhsu",  3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 17);
    do_op("div0",    3'd4, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    do_op("rem0",    3'd6, 1'b0, 64'd100, 64'd0, 64'd100, 1, 1);
    do_op("divovf",  3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1);
    do_op("removf",  3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1);
    do_op("divw",    3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 33);
    do_op("remw",    3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 33);
    do_op("divuw",   3'd5, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 33, 33);
    do_op("mulhw",   3'd1, 1'b1, '1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 65, 17);

    // flush at BUSY cycle 10 of a DIVU, with valid still high in the flush cycle
    op = 3'd5; op_w = 1'b0; rs1 = 64'd1000; rs2 = 64'd7; valid = 1'b1;
    repeat (10) begin @(posedge g_clk); #1; end
    check("flush.pre", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0; valid = 1'b0;
    check("flush.post", {60'd0, busy, ready, busy4, ready4}, 64'd0);
    rc = 0;
    repeat (80) begin @(posedge g_clk); #1; if (ready || busy) rc++; end
    check("flush.quiet", 64'(rc), 64'd0);
    do_op("mul67", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 65, 17);

    // asynchronous reset in the middle of BUSY
    op = 3'd0; op_w = 1'b0; rs1 = 64'h1234; rs2 = 64'd5; valid = 1'b1;
    repeat (20) begin @(posedge g_clk); #1; end
    #2 g_reset = 1'b1;
    #1;
    check("arst.flags", {60'd0, busy, ready, busy4, ready4}, 64'd0);
    check("arst.res", result, 64'd0);
    valid = 1'b0;
    #1 g_reset = 1'b0;
    @(posedge g_clk); #1;
    check("arst.idle", {62'd0, busy, ready}, 64'd0);
    do_op("postrst", 3'd1, 1'b0, -64'sd4, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, 17);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      if ($urandom_range(0, 7) == 0) begin a = 64'h8000_0000_0000_0000; b = '1; end
      do_op("rnd", o, w, a, b, mdl(o, w, a, b), ref_lat(o, w, a, b, 1), ref_lat(o, w, a, b, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
